// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with grant hold, release handshake and
// hold-time watchdog. Registered grant index, valid flag and timeout pulse.
module rr_arbiter_4 #(
  parameter int HOLD_W   = 4,
  parameter int HOLD_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_MAX);
  localparam bit                WD_EN    = (HOLD_MAX != 0);

  state_t            state;
  logic [1:0]        ptr;
  logic [HOLD_W-1:0] hold_cnt;
  logic [1:0]        pick;
  logic [1:0]        cand;
  logic              found;

  // Search ptr, ptr+1, ptr+2, ptr+3 with 2-bit wrap; first requester wins.
  always_comb begin
    pick  = ptr;
    cand  = ptr;
    found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      cand = ptr + 2'(i);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            gnt_idx   <= pick;
            gnt_valid <= 1'b1;
            hold_cnt  <= HOLD_W'(1);
            state     <= GRANT;
          end
        end
        GRANT: begin
          // done and abandon outrank the watchdog, so a coincident expiry
          // is a normal release without a timeout pulse.
          if (done || !req[gnt_idx]) begin
            state     <= IDLE;
            gnt_valid <= 1'b0;
            ptr       <= gnt_idx + 2'd1;
          end else if (WD_EN && (hold_cnt == HOLD_LIM)) begin
            state     <= IDLE;
            gnt_valid <= 1'b0;
            ptr       <= gnt_idx + 2'd1;
            timeout   <= 1'b1;
          end else if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/rr_arbiter_4.md
# rr_arbiter_4

Four-requester round-robin arbiter with grant hold, release handshake and hold-time watchdog. It outputs a registered 2-bit grant index plus a valid flag. It sits directly upstream of the 2-to-4 decoder, which turns `gnt_idx` into one-hot grant lines qualified by `gnt_valid`. Fairness comes from a rotating priority pointer that advances past each owner on release.

## Interface
- `HOLD_W`, 4: width of the hold counter.
- `HOLD_MAX`, 15: maximum consecutive cycles a grant may be held.
  - 0 disables the watchdog.
  - Legal range 0..2^HOLD_W-1.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: reset is synchronous and active-high.
- `req` in 4: request lines; `req[k]` high means requester k wants the resource.
- `done` in 1: the current owner releases the grant; ignored when `gnt_valid`=0.
- `gnt_idx` out 2: index of the granted requester; meaningful only when `gnt_valid`=1.
- `gnt_valid` out 1: a grant is active.
- `timeout` out 1: one-cycle pulse marking a watchdog-forced release.

## Operation
- Two states: IDLE and GRANT. All outputs are registered.
- Reset (`rst`=1 at a rising edge):
  - state=IDLE, `ptr`=0, `gnt_idx`=0, `gnt_valid`=0, `timeout`=0, `hold_cnt`=0.
  - Reset wins over every other event, including mid-grant. The grant drops at the next edge with no `timeout` pulse.
- IDLE:
  - If `req`=0, stay in IDLE with outputs unchanged; `gnt_idx` holds its last value.
  - Otherwise, select the first k with `req[k]`=1, searching in order `ptr`, `ptr`+1, `ptr`+2, `ptr`+3 (mod 4).
  - Load `gnt_idx`=k, set `gnt_valid`=1, set `hold_cnt`=1 and enter GRANT.
- GRANT: release conditions are evaluated each cycle in this priority order.
  - `done`=1: normal release.
  - `req[gnt_idx]`=0: abandon; handled identically to a normal release.
  - `HOLD_MAX`≠0 and `hold_cnt`==`HOLD_MAX`: forced release; set `timeout`=1 for one cycle.
  - Otherwise, `hold_cnt` increments and saturates at 2^HOLD_W-1. It never wraps.
- On any release:
  - Go to IDLE with `gnt_valid`=0.
  - `ptr` = `gnt_idx`+1 (mod 4). The 3→0 wrap is mandatory.
- `done` and watchdog expiry in the same cycle: treated as a normal release, no `timeout` pulse.
- `gnt_idx` is stable for the whole time `gnt_valid`=1. Requests from other requesters during GRANT do not pre-empt the owner.
- Requests are level-sensitive and not latched. A requester that drops `req` before it is selected is not remembered.

## Timing
- Grant latency: `req` sampled high at edge N gives `gnt_valid`=1 with `gnt_idx` valid after edge N, i.e. from cycle N+1.
- Release latency: `done` sampled at edge M gives `gnt_valid`=0 from cycle M+1.
- Each release is followed by exactly one idle cycle. The earliest next grant is valid from cycle M+2.
- Maximum hold: with `HOLD_MAX`=H, `gnt_valid` is high for at most H consecutive cycles. `timeout` is high in the first cycle that `gnt_valid` is low.
- Worst-case wait for a continuously requesting input, with all four requesting: 3×(H+1) idle-plus-grant periods.
- No combinational path from inputs to outputs.

## Test plan
- Reset and idle:
  - Assert `rst` for 2 cycles with `req`=4'b1111.
  - Required: `gnt_valid`=0, `gnt_idx`=0, `timeout`=0 during reset.
  - After `rst` is released: `gnt_idx`=0 granted one cycle later.
- Round-robin rotation:
  - Hold `req`=4'b1111 and pulse `done` 2 cycles after each grant.
  - Required grant sequence 0,1,2,3,0 with one `gnt_valid`=0 cycle between grants.
- Skip and wrap:
  - After owner 2 releases, drive `req`=4'b0011.
  - Required: next grant `gnt_idx`=0 (search 3→0), then 1.
- Watchdog (`HOLD_MAX`=15):
  - Hold `req[1]`=1 with `done`=0.
  - Required: `gnt_valid` high exactly 15 cycles, then low with `timeout`=1 for 1 cycle.
  - Next grant goes to index 2 if requesting, else back to 1.
- Simultaneous events:
  - Assert `done`=1 on the 15th grant cycle. Required: release with `timeout`=0.
  - Separately, drop `req[gnt_idx]`. Required: release at the next edge and `ptr` advances.
- Reset mid-grant:
  - Assert `rst` while `gnt_idx`=3 is valid.
  - Required: `gnt_valid`=0, `timeout`=0 at the next edge.
  - Required: `ptr`=0, so `req`=4'b1010 then grants 1 first.
